// File: rtl/alu_div.sv
// rtl/alu_div.sv - signed restoring divider: 1 cycle load, 8 CALC steps, 1 FIX step
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             DivZero
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_a;
    logic             r_sb;
    logic             r_zero;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH+1:0] w_sh;
    logic             w_fits;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_qneg;
    logic [WIDTH-1:0] w_rneg;

    // Magnitudes are unsigned, so -128 maps cleanly onto 128.
    assign w_mag_a = DataA[WIDTH-1] ? (~DataA + 1'b1) : DataA;
    assign w_mag_b = DataB[WIDTH-1] ? (~DataB + 1'b1) : DataB;
    assign w_sh    = {r_prem, r_dvd[WIDTH-1]};
    assign w_fits  = (w_sh >= {2'b00, r_dsr});
    assign w_sub   = w_sh[WIDTH:0] - {1'b0, r_dsr};
    assign w_qneg  = ~r_dvd + 1'b1;
    assign w_rneg  = ~r_prem[WIDTH-1:0] + 1'b1;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_prem  <= '0;
            r_dvd   <= '0;
            r_dsr   <= '0;
            r_a     <= '0;
            r_sb    <= 1'b0;
            r_zero  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Quot    <= '0;
            Rem     <= '0;
            DivZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state <= S_CALC;
                        r_cnt   <= '0;
                        r_prem  <= '0;
                        r_dvd   <= w_mag_a;
                        r_dsr   <= w_mag_b;
                        r_a     <= DataA;
                        r_sb    <= DataB[WIDTH-1];
                        r_zero  <= (DataB == '0);
                        Busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    // Quotient bits shift into the vacated low end of the dividend register.
                    r_prem <= w_fits ? w_sub : w_sh[WIDTH:0];
                    r_dvd  <= {r_dvd[WIDTH-2:0], w_fits};
                    r_cnt  <= r_cnt + 8'd1;
                    if (r_cnt == 8'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_zero) begin
                        Quot <= '1;
                        Rem  <= r_a;
                    end else begin
                        Quot <= (r_a[WIDTH-1] ^ r_sb) ? w_qneg : r_dvd;
                        Rem  <= r_a[WIDTH-1] ? w_rneg : r_prem[WIDTH-1:0];
                    end
                    DivZero <= r_zero;
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_div.sv
// tb/tb_alu_div.sv - randomized and directed self-checking bench for alu_div
module tb_alu_div;
    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] DataA = 8'h00;
    logic [7:0] DataB = 8'h00;
    logic       Busy, Done, DivZero;
    logic [7:0] Quot, Rem;

    int total = 0;
    int bad   = 0;

    alu_div #(.WIDTH(8)) dut (
        .Clock(Clock), .nReset(nReset), .Start(Start), .DataA(DataA), .DataB(DataB),
        .Busy(Busy), .Done(Done), .Quot(Quot), .Rem(Rem), .DivZero(DivZero)
    );

    always #5 Clock = ~Clock;

    // Reference: integer division truncates toward zero; quotient wraps to 8 bits.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz);
        int ia, ib, iq, ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q = 8'hFF; r = a; dz = 1'b1;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
            q = iq[7:0]; r = ir[7:0]; dz = 1'b0;
        end
    endfunction

    // Drives one Start and returns at the negedge where Done is seen (or the bound expires).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int busy_cnt, output logic seen);
        @(negedge Clock);
        Start = 1'b1; DataA = a; DataB = b;
        @(negedge Clock);
        Start = 1'b0;
        lat = 1; busy_cnt = 0; seen = 1'b0;
        while (lat <= 40) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
            @(negedge Clock);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b);
        int lat, bc;
        logic seen, dz;
        logic [7:0] q, r;
        ref_div(a, b, q, r, dz);
        do_op(a, b, lat, bc, seen);
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s timeout: no Done within 40 cycles (a=%0d b=%0d)", name, $signed(a), $signed(b));
            return;
        end
        total++;
        if (lat !== 10) begin bad++; $display("FAIL %s latency got=%0d exp=10", name, lat); end
        total++;
        if (bc !== 9) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=9", name, bc); end
        total++;
        if (Busy !== 1'b0) begin bad++; $display("FAIL %s busy_in_done got=%b exp=0", name, Busy); end
        total++;
        if ({Quot, Rem, DivZero} !== {q, r, dz}) begin
            bad++;
            $display("FAIL %s a=%0d b=%0d got q=%h r=%h dz=%b exp q=%h r=%h dz=%b",
                     name, $signed(a), $signed(b), Quot, Rem, DivZero, q, r, dz);
        end
        @(negedge Clock);
        total++;
        if (Done !== 1'b0) begin bad++; $display("FAIL %s done_pulse_width got=%b exp=0", name, Done); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clock);
        total++;
        if ({Busy, Done, Quot, Rem, DivZero} !== 19'd0) begin
            bad++; $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dz=%b exp all 0",
                            Busy, Done, Quot, Rem, DivZero);
        end
        nReset = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [14] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'd127,
                                8'd5, 8'd6, 8'd0, 8'h81, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] tb [14] = '{8'd7, 8'd7, 8'hF9, 8'hF9, 8'hFF, 8'd1, 8'h80,
                                8'd0, 8'd3, 8'd9, 8'h80, 8'h7F, 8'h80, 8'h00};
        for (int i = 0; i < 14; i++) check_op($sformatf("directed%0d", i), ta[i], tb[i]);
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            check_op($sformatf("random%0d", i), a, b);
        end
    endtask

    task automatic test_busy_ignore();
        int dones = 0;
        @(negedge Clock);
        Start = 1'b1; DataA = 8'd9; DataB = 8'd2;
        @(negedge Clock);
        Start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 3) begin Start = 1'b1; DataA = 8'd50; DataB = 8'd5; end
            if (c == 4) begin Start = 1'b0; DataA = 8'd77; end
            if (Done) begin
                dones++;
                total++;
                if (Quot !== 8'h04 || Rem !== 8'h01) begin
                    bad++; $display("FAIL busy_ignore result got q=%h r=%h exp q=04 r=01", Quot, Rem);
                end
            end
            @(negedge Clock);
        end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL busy_ignore done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        int lat, bc, c;
        logic seen;
        do_op(8'd20, 8'd3, lat, bc, seen);
        total++;
        if (!seen) begin bad++; $display("FAIL b2b first timeout got no Done exp Done"); return; end
        Start = 1'b1; DataA = 8'd50; DataB = 8'd5;
        @(negedge Clock);
        Start = 1'b0;
        c = 1;
        while (c <= 30 && !Done) begin @(negedge Clock); c++; end
        total++;
        if (c !== 10) begin bad++; $display("FAIL b2b latency got=%0d exp=10", c); end
        total++;
        if (Quot !== 8'h0A || Rem !== 8'h00 || DivZero !== 1'b0) begin
            bad++; $display("FAIL b2b result got q=%h r=%h dz=%b exp q=0a r=00 dz=0", Quot, Rem, DivZero);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        check_op("pre_reset", 8'd100, 8'd7);
        @(negedge Clock);
        Start = 1'b1; DataA = 8'd90; DataB = 8'd4;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        nReset = 1'b0;
        #1;
        total++;
        if ({Busy, Done, Quot, Rem, DivZero} !== 19'd0) begin
            bad++; $display("FAIL reset_mid async got busy=%b done=%b q=%h r=%h dz=%b exp all 0",
                            Busy, Done, Quot, Rem, DivZero);
        end
        repeat (2) @(negedge Clock);
        nReset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (Done) dones++;
            @(negedge Clock);
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL reset_mid spurious_done got=%0d exp=0", dones); end
        check_op("post_reset", 8'd20, 8'd6);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_div.md
# alu_div

Sequential signed 8-bit divider for picoMips. It performs the inverse of the ALU multiply path and returns quotient and remainder of `DataA / DataB` after a fixed 9-cycle iteration. It sits beside the ALU on the same operand buses, is started by the control unit with a one-cycle `Start` pulse, and reports completion with a one-cycle `Done` pulse. Results are held until the next operation completes.

## Interface
- `WIDTH`, default 8: operand and result width. Only 8 is verified.
- `Clock`, input, 1: single system clock. All state updates on the rising edge.
- `nReset`, input, 1: asynchronous, active-low reset.
- `Start`, input, 1: begin a division. Sampled only in IDLE.
- `DataA`, input, 8: signed dividend. Latched on the accepted `Start`.
- `DataB`, input, 8: signed divisor. Latched on the accepted `Start`.
- `Busy`, output, 1: high while an operation is in progress.
- `Done`, output, 1: one-cycle pulse when results become valid.
- `Quot`, output, 8: signed quotient.
- `Rem`, output, 8: signed remainder.
- `DivZero`, output, 1: the last completed operation had `DataB == 0`. Held with `Quot`/`Rem`.

## Operation
- States are IDLE, CALC, FIX.
  - IDLE: if `Start` is high, go to CALC. In the same edge:
    - latch the operand signs;
    - latch the magnitudes as 8-bit unsigned, so |−128| = 128 is representable;
    - latch the zero-divisor flag;
    - clear the 8-bit iteration counter and the 9-bit partial remainder.
  - CALC: perform one restoring-division step per cycle.
    - Shift {partial remainder, dividend magnitude} left by 1.
    - Trial-subtract the divisor magnitude from the 9-bit partial remainder.
    - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
    - After the 8th step, go to FIX.
  - FIX: apply sign correction and register the outputs, then go to IDLE.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
- Rounding is truncation toward zero, and the identity A = Q·B + R holds, except in the two cases below.
- Overflow case, −128 / −1: `Quot` = 8'h80 (two's-complement wrap), `Rem` = 8'h00, `DivZero` = 0.
- Divide by zero: latency is unchanged, with no early exit. `Quot` = 8'hFF, `Rem` = latched `DataA`, `DivZero` = 1.
- Operands are captured only on the accepted `Start`. Changes to `DataA`/`DataB` while `Busy` is high have no effect.
- `Start` while `Busy` is high is ignored. It is not queued and does not restart the operation.

## Timing
- Reset values: `Busy` = 0, `Done` = 0, `Quot` = 8'h00, `Rem` = 8'h00, `DivZero` = 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values and no `Done` is produced.
- Let `Start` be accepted at rising edge N.
  - `Busy` is high from edge N through edge N+9, i.e. for 9 cycles.
  - Edges N+1 to N+8 perform the 8 CALC steps.
  - Edge N+9 performs FIX and updates `Quot`, `Rem` and `DivZero` together.
  - `Done` is high for exactly the cycle following edge N+9.
  - `Busy` is low in the cycle where `Done` is high.
- Throughput: a `Start` sampled high during the `Done` cycle is accepted, because the state is IDLE. Back-to-back operations therefore run every 10 cycles.
- `Quot`, `Rem` and `DivZero` change only at FIX edges or at reset. They are stable between completions.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Positive operands: `DataA` = 100, `DataB` = 7, `Start` at edge N.
  - `Busy` high for edges N..N+9.
  - `Done` in the cycle after N+9, with `Quot` = 8'h0E, `Rem` = 8'h02, `DivZero` = 0.
- Signed operands:
  - −100 / 7 gives `Quot` = 8'hF2 (−14), `Rem` = 8'hFE (−2).
  - 100 / −7 gives `Quot` = 8'hF2, `Rem` = 8'h02.
  - −100 / −7 gives `Quot` = 8'h0E, `Rem` = 8'hFE.
- Extremes:
  - −128 / −1 gives `Quot` = 8'h80, `Rem` = 8'h00.
  - −128 / 1 gives `Quot` = 8'h80, `Rem` = 8'h00.
  - 127 / −128 gives `Quot` = 8'h00, `Rem` = 8'h7F.
- Divide by zero: 5 / 0.
  - `Done` arrives with the normal 10-cycle latency.
  - `Quot` = 8'hFF, `Rem` = 8'h05, `DivZero` = 1.
  - A following 6 / 3 clears `DivZero` and gives `Quot` = 8'h02, `Rem` = 8'h00.
- Handshake:
  - Start 9 / 2, then pulse `Start` with 50 / 5 at N+3 and change `DataA` at N+4. Result must be `Quot` = 8'h04, `Rem` = 8'h01, with exactly one `Done`.
  - Asserting `Start` with 50 / 5 during the `Done` cycle gives a second `Done` 10 cycles later, with `Quot` = 8'h0A.
- Reset mid-operation: assert `nReset` low at N+5 of an active division.
  - All outputs go to 0 asynchronously and no `Done` follows.
  - After release, a new 20 / 6 gives `Quot` = 8'h03, `Rem` = 8'h02.
